// File: rtl/pipeline_ctrl.sv
// Hazard and memory-wait controller for a five-stage in-order pipeline.
// It resolves load-use hazards, ID-stage redirects and data-memory wait
// states, and keeps stall and flush performance counters.
//
// Ports:
//   clk_i, rst_i          clock; asynchronous active-high reset
//   start_i               run enable
//   idex_memread_i/rt_i   load in EX and its destination register
//   ifid_rs_i/rt_i        source registers of the instruction in ID
//   branch_taken_i/jump_i ID-stage redirect
//   exmem_memread_i/..w.. data-memory access in MEM
//   dmem_req_o/dmem_ack_i data-memory handshake
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//   pipe_hold_o, memwb_bubble_o   pipeline steering (decoded from state + inputs)
//   state_o, error_o      FSM state and sticky timeout error
//   stall_cnt_o, flush_cnt_o      saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        exmem_memread_i,
  input  logic        exmem_memwrite_i,
  output logic        dmem_req_o,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_hold_o,
  output logic        memwb_bubble_o,
  output logic [1:0]  state_o,
  output logic        error_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int unsigned TMO_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             mem_stall_c;
  logic             load_use_c;
  logic             redirect_c;
  logic             active_c;

  assign load_use_c = idex_memread_i & (idex_rt_i != 5'd0) &
                      ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
  assign redirect_c = branch_taken_i | jump_i;
  assign active_c   = (state_q == ST_RUN) | (state_q == ST_MEMWAIT);
  assign state_o    = state_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stalled access always completes before start_i=0 is honoured
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall_c)  state_d = ST_MEMWAIT;
        else if (!start_i) state_d = ST_IDLE;
      end
      ST_MEMWAIT: begin
        // ack wins over a timeout landing in the same cycle
        if (dmem_ack_i)                 state_d = ST_RUN;
        else if (tmo_cnt_q == TMO_LAST) state_d = ST_ERROR;
      end
      default: state_d = ST_ERROR;
    endcase
  end

  // Output decode: priority mem_stall > load_use > redirect > normal advance
  always_comb begin
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    pipe_hold_o    = 1'b1;
    memwb_bubble_o = 1'b1;
    dmem_req_o     = 1'b0;
    mem_stall_c    = 1'b0;
    case (state_q)
      ST_RUN:     dmem_req_o = exmem_memread_i | exmem_memwrite_i;
      ST_MEMWAIT: dmem_req_o = 1'b1;
      default:    dmem_req_o = 1'b0;
    endcase
    if (active_c) begin
      mem_stall_c = dmem_req_o & ~dmem_ack_i;
      if (!mem_stall_c) begin
        pipe_hold_o    = 1'b0;
        memwb_bubble_o = 1'b0;
        if (load_use_c) begin
          idex_bubble_o = 1'b1;
        end else if (redirect_c) begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
        end
      end
    end
  end

  // MEMWAIT timeout counter, cleared on entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_MEMWAIT) begin
      tmo_cnt_q <= '0;
    end else if (!dmem_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Sticky error flag, mirrors entry into ERROR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      error_o <= 1'b0;
    end else if (state_d == ST_ERROR) begin
      error_o <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (active_c && !pc_write_o && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (ifid_flush_o && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT = 4).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        branch_taken;
  logic        jump;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_hold;
  logic        memwb_bubble;
  logic [1:0]  state;
  logic        error;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, dmem_req}
  logic [6:0]  ctl;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, dmem_req};

  localparam logic [6:0] C_IDLE  = 7'b0000110;
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_MSTL  = 7'b0000111;
  localparam logic [6:0] C_ACK   = 7'b1100001;
  localparam logic [6:0] C_FLUSH = 7'b1110000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .idex_memread_i  (idex_memread),
    .idex_rt_i       (idex_rt),
    .ifid_rs_i       (ifid_rs),
    .ifid_rt_i       (ifid_rt),
    .branch_taken_i  (branch_taken),
    .jump_i          (jump),
    .exmem_memread_i (exmem_memread),
    .exmem_memwrite_i(exmem_memwrite),
    .dmem_req_o      (dmem_req),
    .dmem_ack_i      (dmem_ack),
    .pc_write_o      (pc_write),
    .ifid_write_o    (ifid_write),
    .ifid_flush_o    (ifid_flush),
    .idex_bubble_o   (idex_bubble),
    .pipe_hold_o     (pipe_hold),
    .memwb_bubble_o  (memwb_bubble),
    .state_o         (state),
    .error_o         (error),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  task automatic clear_hazards;
    idex_memread   = 1'b0;
    idex_rt        = 5'd0;
    ifid_rs        = 5'd0;
    ifid_rt        = 5'd0;
    branch_taken   = 1'b0;
    jump           = 1'b0;
    exmem_memread  = 1'b0;
    exmem_memwrite = 1'b0;
    dmem_ack       = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; clear_hazards();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ctl !== C_IDLE) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({error, stall_cnt, flush_cnt} !== 33'd0) begin n_bad++; $display("FAIL reset_regs: err %b stall %0d flush %0d want 0", error, stall_cnt, flush_cnt); end
  endtask

  task automatic test_start;
    @(negedge clk); rst = 1'b0; start = 1'b1; #1;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL start_still_idle: got %0d want 0", state); end
    @(negedge clk); #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_run: got %0d want 1", state); end
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL start_ctl: got %b want %b", ctl, C_RUN); end
    n_cmp++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_bad++; $display("FAIL start_cnt: stall %0d flush %0d want 0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use;
    @(negedge clk); idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #1;
    n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, C_LU); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL lu_release: got %b want %b", ctl, C_RUN); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    @(negedge clk); idex_memread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; #1;
    n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, C_LU); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL lu_rt_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_no_hazard;
    @(negedge clk); idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL r0_ctl: got %b want %b", ctl, C_RUN); end
    @(negedge clk); idex_rt = 5'd5; ifid_rs = 5'd4; ifid_rt = 5'd6; #1;
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL nomatch_ctl: got %b want %b", ctl, C_RUN); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL nohaz_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_mem_wait;
    @(negedge clk); exmem_memread = 1'b1; #1;
    n_cmp++; if (ctl !== C_MSTL) begin n_bad++; $display("FAIL mw_first_ctl: got %b want %b", ctl, C_MSTL); end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL mw_first_state: got %0d want 1", state); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if ({state, ctl} !== {2'd2, C_MSTL}) begin n_bad++; $display("FAIL mw_wait%0d: state %0d ctl %b want 2 %b", i, state, ctl, C_MSTL); end
    end
    @(negedge clk); dmem_ack = 1'b1; #1;
    n_cmp++; if ({state, ctl} !== {2'd2, C_ACK}) begin n_bad++; $display("FAIL mw_ack: state %0d ctl %b want 2 %b", state, ctl, C_ACK); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL mw_back_run: got %0d want 1", state); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL mw_stall_cnt: got %0d want 5", stall_cnt); end
    // zero-wait access: ack with the request
    @(negedge clk); exmem_memwrite = 1'b1; dmem_ack = 1'b1; #1;
    n_cmp++; if (ctl !== C_ACK) begin n_bad++; $display("FAIL zw_ctl: got %b want %b", ctl, C_ACK); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if ({state, stall_cnt} !== {2'd1, 16'd5}) begin n_bad++; $display("FAIL zw_after: state %0d stall %0d want 1 5", state, stall_cnt); end
  endtask

  task automatic test_redirect;
    @(negedge clk); branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; #1;
    n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL rd_suppressed: got %b want %b", ctl, C_LU); end
    @(negedge clk); idex_memread = 1'b0; ifid_rs = 5'd0; #1;
    n_cmp++; if (ctl !== C_FLUSH) begin n_bad++; $display("FAIL rd_flush: got %b want %b", ctl, C_FLUSH); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if ({flush_cnt, stall_cnt} !== {16'd1, 16'd6}) begin n_bad++; $display("FAIL rd_cnts: flush %0d stall %0d want 1 6", flush_cnt, stall_cnt); end
    @(negedge clk); jump = 1'b1; exmem_memwrite = 1'b1; dmem_ack = 1'b1; #1;
    n_cmp++; if (ctl !== (C_FLUSH | 7'b0000001)) begin n_bad++; $display("FAIL rd_zw_jump: got %b want 1110001", ctl); end
    @(negedge clk); jump = 1'b1; exmem_memwrite = 1'b1; dmem_ack = 1'b0; #1;
    n_cmp++; if (ctl !== C_MSTL) begin n_bad++; $display("FAIL rd_memstall_prio: got %b want %b", ctl, C_MSTL); end
    @(negedge clk); jump = 1'b0; exmem_memwrite = 1'b0; dmem_ack = 1'b1; #1;
    n_cmp++; if ({state, ctl} !== {2'd2, C_ACK}) begin n_bad++; $display("FAIL rd_mw_ack: state %0d ctl %b want 2 %b", state, ctl, C_ACK); end
    @(negedge clk); clear_hazards(); #1;
    n_cmp++; if ({state, flush_cnt, stall_cnt} !== {2'd1, 16'd2, 16'd7}) begin n_bad++; $display("FAIL rd_end: state %0d flush %0d stall %0d want 1 2 7", state, flush_cnt, stall_cnt); end
  endtask

  task automatic test_stop_during_wait;
    @(negedge clk); start = 1'b0; exmem_memread = 1'b1; #1;
    n_cmp++; if (ctl !== C_MSTL) begin n_bad++; $display("FAIL stop_stall_ctl: got %b want %b", ctl, C_MSTL); end
    @(negedge clk); exmem_memread = 1'b0; #1;
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL stop_wait1: got %0d want 2", state); end
    @(negedge clk); dmem_ack = 1'b1; #1;
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL stop_wait2: got %0d want 2", state); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL stop_run: got %0d want 1", state); end
    @(negedge clk); #1;
    n_cmp++; if ({state, ctl, stall_cnt} !== {2'd0, C_IDLE, 16'd9}) begin n_bad++; $display("FAIL stop_idle: state %0d ctl %b stall %0d want 0 %b 9", state, ctl, stall_cnt, C_IDLE); end
  endtask

  task automatic test_timeout;
    @(negedge clk); start = 1'b1;
    @(negedge clk); exmem_memread = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL to_wait%0d: got %0d want 2", i, state); end
    end
    @(negedge clk); #1;
    n_cmp++; if ({state, error} !== {2'd3, 1'b1}) begin n_bad++; $display("FAIL to_error: state %0d err %b want 3 1", state, error); end
    n_cmp++; if (ctl !== C_IDLE) begin n_bad++; $display("FAIL to_err_ctl: got %b want %b", ctl, C_IDLE); end
    n_cmp++; if (stall_cnt !== 16'd14) begin n_bad++; $display("FAIL to_stall_cnt: got %0d want 14", stall_cnt); end
    @(negedge clk); dmem_ack = 1'b1; #1;
    @(negedge clk); #1;
    n_cmp++; if ({state, error} !== {2'd3, 1'b1}) begin n_bad++; $display("FAIL to_sticky: state %0d err %b want 3 1", state, error); end
    rst = 1'b1; #1;
    n_cmp++; if ({state, error, stall_cnt, flush_cnt} !== 35'd0) begin n_bad++; $display("FAIL to_reset: state %0d err %b stall %0d flush %0d want 0", state, error, stall_cnt, flush_cnt); end
    n_cmp++; if (ctl !== C_IDLE) begin n_bad++; $display("FAIL to_reset_ctl: got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_reset_in_memwait;
    @(negedge clk); rst = 1'b0; start = 1'b1; clear_hazards();
    @(negedge clk); exmem_memread = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({state, dmem_req} !== {2'd2, 1'b1}) begin n_bad++; $display("FAIL rm_wait: state %0d req %b want 2 1", state, dmem_req); end
    #2; rst = 1'b1; #1;
    n_cmp++; if ({state, dmem_req} !== {2'd0, 1'b0}) begin n_bad++; $display("FAIL rm_drop: state %0d req %b want 0 0", state, dmem_req); end
    @(negedge clk); rst = 1'b0; exmem_memread = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({state, ctl, stall_cnt} !== {2'd1, C_RUN, 16'd0}) begin n_bad++; $display("FAIL rm_resume: state %0d ctl %b stall %0d want 1 %b 0", state, ctl, stall_cnt, C_RUN); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_redirect();
    test_stop_during_wait();
    test_timeout();
    test_reset_in_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
